// File: rtl/sync_pkg.sv
// Shared types and default constants for the toggle-handshake request sender
// and its helpers.
package sync_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam int DEF_CNT_W       = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/sync_nff.sv
// Generic N-flop single-bit synchronizer with synchronous active-high reset.
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/sync_req_tx.sv
// Toggle-handshake event sender with a pending-event counter.
// Optional acknowledge timeout enabled by defining SYNC_REQ_TX_TIMEOUT_EN.
module sync_req_tx
  import sync_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             pulse_in,
  input  logic             ack_toggle_in,
  output logic             req_toggle,
  output logic             busy,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             done,
  output logic             overflow,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("sync_req_tx: illegal parameter value");
  end

  state_t state;
  logic   ack_s;
  logic   launch;
  logic   full;

  sync_nff #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk_in),
    .reset (reset),
    .d     (ack_toggle_in),
    .q     (ack_s)
  );

  assign launch = (state == IDLE) && ((pending_cnt != '0) || pulse_in);
  assign full   = &pending_cnt;

  // A pulse arriving on a launch cycle is consumed by that launch, so the
  // count only moves when exactly one of the two happens.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pending_cnt <= '0;
      overflow    <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (pulse_in && !launch) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          pending_cnt <= pending_cnt + CNT_ONE;
        end
      end else if (!pulse_in && launch) begin
        pending_cnt <= pending_cnt - CNT_ONE;
      end
    end
  end

`ifdef SYNC_REQ_TX_TIMEOUT_EN
  localparam int          TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tcnt;
`endif

  // Transfer completes when the synchronized ack catches up with req_toggle.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      req_toggle <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SYNC_REQ_TX_TIMEOUT_EN
      tcnt        <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            req_toggle <= ~req_toggle;
            busy       <= 1'b1;
            state      <= WAIT_ACK;
`ifdef SYNC_REQ_TX_TIMEOUT_EN
            tcnt       <= '0;
`endif
          end
        end
        WAIT_ACK: begin
          if (ack_s == req_toggle) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
`ifdef SYNC_REQ_TX_TIMEOUT_EN
          else if (tcnt == T_LAST) begin
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ERR;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
`ifdef SYNC_REQ_TX_TIMEOUT_EN
        ERR: begin
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNC_REQ_TX_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_req_tx.sv
// Directed self-checking bench for sync_req_tx (CNT_W=4, SYNC_STAGES=2).
// The receiver is modelled as a direct loopback, a one-flop loopback or a held level.
module tb_sync_req_tx;

  localparam int CNT_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CYC = 8;

  logic             clk_in = 1'b0;
  logic             reset;
  logic             pulse_in;
  logic             ack_toggle_in;
  logic             req_toggle;
  logic             busy;
  logic [CNT_W-1:0] pending_cnt;
  logic             done;
  logic             overflow;
  logic             timeout_err;

  logic [1:0] ack_mode;
  logic       ack_hold;
  logic       ack_reg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (reset) ack_reg <= 1'b0;
    else       ack_reg <= req_toggle;
  end

  assign ack_toggle_in = (ack_mode == 2'd1) ? req_toggle :
                         (ack_mode == 2'd2) ? ack_reg : ack_hold;

  sync_req_tx #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .pulse_in      (pulse_in),
    .ack_toggle_in (ack_toggle_in),
    .req_toggle    (req_toggle),
    .busy          (busy),
    .pending_cnt   (pending_cnt),
    .done          (done),
    .overflow      (overflow),
    .timeout_err   (timeout_err)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    pulse_in = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    pulse_in = 1'b1;
    ack_mode = 2'd0;
    ack_hold = 1'b1;
    step();
    step();
    total_cnt++;
    if ({req_toggle, busy, done, overflow, timeout_err} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %05b expected 00000", {req_toggle, busy, done, overflow, timeout_err});
    else pass_cnt++;
    total_cnt++;
    if (pending_cnt !== 4'd0) $display("[TB] FAIL reset_cnt: got %0d expected 0", pending_cnt);
    else pass_cnt++;
    reset    = 1'b0;
    pulse_in = 1'b0;
    ack_hold = 1'b0;
    step();
  endtask

  task automatic test_single();
    ack_mode = 2'd1;
    pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
    total_cnt++;
    if ({req_toggle, busy} !== 2'b11) $display("[TB] FAIL single_launch req/busy: got %02b expected 11", {req_toggle, busy});
    else pass_cnt++;
    total_cnt++;
    if (pending_cnt !== 4'd0) $display("[TB] FAIL single_cnt: got %0d expected 0", pending_cnt);
    else pass_cnt++;
    for (int k = 1; k <= SYNC_STAGES; k++) begin
      step();
      total_cnt++;
      if ({done, busy} !== 2'b01) $display("[TB] FAIL single_wait%0d done/busy: got %02b expected 01", k, {done, busy});
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if ({done, busy} !== 2'b10) $display("[TB] FAIL single_done done/busy: got %02b expected 10", {done, busy});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({done, busy, req_toggle} !== 3'b001) $display("[TB] FAIL single_after done/busy/req: got %03b expected 001", {done, busy, req_toggle});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int flips = 0;
    int dones = 0;
    int peak  = 0;
    int ovfs  = 0;
    logic prev;
    ack_mode = 2'd2;
    prev = req_toggle;
    for (int i = 0; i < 40; i++) begin
      pulse_in = (i < 5);
      step();
      if (req_toggle !== prev) flips++;
      prev = req_toggle;
      if (done === 1'b1) dones++;
      if (overflow === 1'b1) ovfs++;
      if (int'(pending_cnt) > peak) peak = int'(pending_cnt);
    end
    pulse_in = 1'b0;
    total_cnt++;
    if (peak !== 4) $display("[TB] FAIL burst_peak: got %0d expected 4", peak);
    else pass_cnt++;
    total_cnt++;
    if (flips !== 5) $display("[TB] FAIL burst_flips: got %0d expected 5", flips);
    else pass_cnt++;
    total_cnt++;
    if (dones !== 5) $display("[TB] FAIL burst_dones: got %0d expected 5", dones);
    else pass_cnt++;
    total_cnt++;
    if ({pending_cnt, busy} !== 5'b0 || ovfs !== 0)
      $display("[TB] FAIL burst_final cnt/busy/ovf: got %0d/%0b/%0d expected 0/0/0", pending_cnt, busy, ovfs);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int ovfs    = 0;
    int ovf_idx = -1;
    ack_mode = 2'd0;
    ack_hold = 1'b0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      pulse_in = 1'b1;
      step();
      if (overflow === 1'b1) begin
        ovfs++;
        ovf_idx = i;
      end
      if (i == 15) begin
        total_cnt++;
        if (pending_cnt !== 4'd15) $display("[TB] FAIL ovf_fill: got %0d expected 15", pending_cnt);
        else pass_cnt++;
      end
    end
    pulse_in = 1'b0;
    total_cnt++;
    if (ovfs !== 1 || ovf_idx !== 16) $display("[TB] FAIL ovf_pulse count/index: got %0d/%0d expected 1/16", ovfs, ovf_idx);
    else pass_cnt++;
    total_cnt++;
    if (pending_cnt !== 4'd15) $display("[TB] FAIL ovf_sat: got %0d expected 15", pending_cnt);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({overflow, pending_cnt} !== {1'b0, 4'd15}) $display("[TB] FAIL ovf_after ovf/cnt: got %0b/%0d expected 0/15", overflow, pending_cnt);
    else pass_cnt++;
  endtask

  task automatic test_full_launch();
    ack_hold = 1'b1;
    for (int k = 0; k < SYNC_STAGES; k++) step();
    step();
    total_cnt++;
    if ({done, busy, pending_cnt} !== {1'b1, 1'b0, 4'd15})
      $display("[TB] FAIL full_done done/busy/cnt: got %0b/%0b/%0d expected 1/0/15", done, busy, pending_cnt);
    else pass_cnt++;
    pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
    total_cnt++;
    if ({overflow, pending_cnt} !== {1'b0, 4'd15}) $display("[TB] FAIL full_launch ovf/cnt: got %0b/%0d expected 0/15", overflow, pending_cnt);
    else pass_cnt++;
    total_cnt++;
    if ({req_toggle, busy} !== 2'b01) $display("[TB] FAIL full_launch req/busy: got %02b expected 01", {req_toggle, busy});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    ack_mode = 2'd0;
    ack_hold = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse_in = 1'b1;
      step();
    end
    pulse_in = 1'b0;
    total_cnt++;
    if ({busy, req_toggle, pending_cnt} !== {2'b11, 4'd3}) $display("[TB] FAIL mid_setup busy/req/cnt: got %0b/%0b/%0d expected 1/1/3", busy, req_toggle, pending_cnt);
    else pass_cnt++;
    reset = 1'b1;
    step();
    total_cnt++;
    if ({req_toggle, busy, done, overflow, timeout_err, pending_cnt} !== 9'b0)
      $display("[TB] FAIL mid_reset outputs: got %09b expected 000000000", {req_toggle, busy, done, overflow, timeout_err, pending_cnt});
    else pass_cnt++;
    reset = 1'b0;
    step();
    total_cnt++;
    if ({req_toggle, busy, pending_cnt} !== 6'b0) $display("[TB] FAIL mid_idle req/busy/cnt: got %0b/%0b/%0d expected 0/0/0", req_toggle, busy, pending_cnt);
    else pass_cnt++;
  endtask

`ifdef SYNC_REQ_TX_TIMEOUT_EN
  task automatic test_timeout();
    ack_mode = 2'd0;
    ack_hold = 1'b0;
    do_reset();
    pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
    for (int k = 1; k < TIMEOUT_CYC; k++) step();
    total_cnt++;
    if ({timeout_err, busy} !== 2'b01) $display("[TB] FAIL tmo_early err/busy: got %02b expected 01", {timeout_err, busy});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({timeout_err, busy} !== 2'b10) $display("[TB] FAIL tmo_hit err/busy: got %02b expected 10", {timeout_err, busy});
    else pass_cnt++;
    pulse_in = 1'b1;
    step();
    step();
    pulse_in = 1'b0;
    step();
    total_cnt++;
    if ({timeout_err, req_toggle, pending_cnt} !== {2'b11, 4'd2})
      $display("[TB] FAIL tmo_err_hold err/req/cnt: got %0b/%0b/%0d expected 1/1/2", timeout_err, req_toggle, pending_cnt);
    else pass_cnt++;
  endtask
`endif

  initial begin
    reset    = 1'b1;
    pulse_in = 1'b0;
    ack_mode = 2'd0;
    ack_hold = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
`ifndef SYNC_REQ_TX_TIMEOUT_EN
    test_full_launch();
`endif
    test_reset_mid();
`ifdef SYNC_REQ_TX_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
